llsc_reservation_unit: RTL and testbench

- Multi-channel LL/SC reservation monitor replacing the single LLbit register of the OpenMIPS core.
- Tracks one linked address per hardware channel (core/thread) at configurable granule size.
- Decides SC success in the MEM stage and invalidates reservations on conflicting stores, external-master writes, exceptions and optional timeout.
- Sits beside the MEM stage; CP0 reads llbit/lladdr from it.

---
 rtl/llsc_reservation_unit_pkg.sv | 16 +
 rtl/llsc_link_entry.sv | 63 ++++++
 rtl/llsc_reservation_unit.sv | 113 +++++++++++
 tb/tb_llsc_reservation_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/llsc_reservation_unit_pkg.sv
// Shared constants and helpers for the LL/SC reservation monitor.
// Covers the default granule, the per-channel bus slicing, and the age counter width.
package llsc_reservation_unit_pkg;

    localparam int LLSC_GRAN_DEFAULT = 2;

    // One spare bit keeps the counter legal when timeout is disabled
    function automatic int llsc_age_width(input int timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

    function automatic int llsc_slice_lo(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/llsc_link_entry.sv
// One channel's reservation: valid bit, granule tag and optional expiry age.
// Priority from highest: reset, flush, LL, SC, kill, timeout.
module llsc_link_entry
    import llsc_reservation_unit_pkg::*;
#(
    parameter int TAG_W   = 30,
    parameter int TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_ll_set,
    input  logic [TAG_W-1:0] i_ll_tag,
    input  logic             i_sc_req,
    input  logic             i_kill,
    output logic             o_valid,
    output logic [TAG_W-1:0] o_tag
);

    logic             r_valid;
    logic [TAG_W-1:0] r_tag;
    logic             w_expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_ll_set) begin
            r_valid <= 1'b1;
            r_tag   <= i_ll_tag;
        end else if (i_sc_req || i_kill || w_expire) begin
            r_valid <= 1'b0;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_age
            localparam int AGE_W = llsc_age_width(TIMEOUT);
            localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT - 1);

            logic [AGE_W-1:0] r_age;

            // Age restarts on every LL so a re-link gets a fresh lease
            always_ff @(posedge clk) begin
                if (rst || i_ll_set) begin
                    r_age <= '0;
                end else if (r_valid && (r_age != '1)) begin
                    r_age <= r_age + AGE_W'(1);
                end
            end

            assign w_expire = r_valid && (r_age == AGE_LAST);
        end else begin : g_no_age
            assign w_expire = 1'b0;
        end
    endgenerate

    assign o_valid = r_valid;
    assign o_tag   = r_tag;

endmodule

// File: rtl/llsc_reservation_unit.sv
// Multi-channel LL/SC reservation monitor beside the MEM stage.
// Holds per-channel links and the cross-channel kill / SC arbitration matrix.
module llsc_reservation_unit
    import llsc_reservation_unit_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int ADDR_W    = 32,
    parameter int GRAN_LOG2 = LLSC_GRAN_DEFAULT,
    parameter int TIMEOUT   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          ll_we,
    input  logic [N_CH*ADDR_W-1:0]   ll_addr,
    input  logic [N_CH-1:0]          sc_req,
    input  logic [N_CH*ADDR_W-1:0]   sc_addr,
    output logic [N_CH-1:0]          sc_ok,
    input  logic [N_CH-1:0]          st_we,
    input  logic [N_CH*ADDR_W-1:0]   st_addr,
    input  logic                     ext_wr,
    input  logic [ADDR_W-1:0]        ext_addr,
    input  logic [N_CH-1:0]          flush,
    output logic [N_CH-1:0]          llbit,
    output logic [N_CH*ADDR_W-1:0]   lladdr
);

    localparam int TAG_W = ADDR_W - GRAN_LOG2;

    logic [N_CH-1:0]  w_valid;
    logic [TAG_W-1:0] w_tag    [N_CH];
    logic [TAG_W-1:0] w_ll_tag [N_CH];
    logic [TAG_W-1:0] w_sc_tag [N_CH];
    logic [TAG_W-1:0] w_st_tag [N_CH];
    logic [TAG_W-1:0] w_ext_tag;
    logic [N_CH-1:0]  w_wr_kill;
    logic [N_CH-1:0]  w_kill;
    logic [N_CH-1:0]  w_sc_ok;
    logic             w_unused_low;

    assign w_ext_tag    = ext_addr[ADDR_W-1:GRAN_LOG2];
    assign w_unused_low = ^{ll_addr, sc_addr, st_addr, ext_addr};

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            assign w_ll_tag[g] = ll_addr[llsc_slice_lo(g, ADDR_W) + GRAN_LOG2 +: TAG_W];
            assign w_sc_tag[g] = sc_addr[llsc_slice_lo(g, ADDR_W) + GRAN_LOG2 +: TAG_W];
            assign w_st_tag[g] = st_addr[llsc_slice_lo(g, ADDR_W) + GRAN_LOG2 +: TAG_W];

            llsc_link_entry #(
                .TAG_W   (TAG_W),
                .TIMEOUT (TIMEOUT)
            ) u_entry (
                .clk      (clk),
                .rst      (rst),
                .i_flush  (flush[g]),
                .i_ll_set (ll_we[g]),
                .i_ll_tag (w_ll_tag[g]),
                .i_sc_req (sc_req[g]),
                .i_kill   (w_kill[g]),
                .o_valid  (w_valid[g]),
                .o_tag    (w_tag[g])
            );

            assign lladdr[llsc_slice_lo(g, ADDR_W) +: ADDR_W] = ADDR_W'(w_tag[g]) << GRAN_LOG2;
        end
    endgenerate

    // SC winners are resolved in ascending channel order so a lower channel's
    // successful SC blocks any higher channel on the same granule without a loop
    always_comb begin
        w_wr_kill = '0;
        w_sc_ok   = '0;
        w_kill    = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ext_wr && w_valid[c] && (w_ext_tag == w_tag[c])) begin
                w_wr_kill[c] = 1'b1;
            end
            for (int j = 0; j < N_CH; j++) begin
                if ((j != c) && st_we[j] && w_valid[c] && (w_st_tag[j] == w_tag[c])) begin
                    w_wr_kill[c] = 1'b1;
                end
            end
        end
        for (int c = 0; c < N_CH; c++) begin
            w_sc_ok[c] = !rst && sc_req[c] && w_valid[c] && (w_sc_tag[c] == w_tag[c])
                         && !flush[c] && !w_wr_kill[c];
            for (int j = 0; j < c; j++) begin
                if (w_sc_ok[j] && (w_sc_tag[j] == w_tag[c])) begin
                    w_sc_ok[c] = 1'b0;
                end
            end
        end
        for (int c = 0; c < N_CH; c++) begin
            w_kill[c] = w_wr_kill[c];
            for (int j = 0; j < N_CH; j++) begin
                if ((j != c) && w_sc_ok[j] && w_valid[c] && (w_sc_tag[j] == w_tag[c])) begin
                    w_kill[c] = 1'b1;
                end
            end
        end
    end

    assign sc_ok = w_sc_ok;
    assign llbit = w_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(|(ll_we & sc_req)));
        end
    end

endmodule

// File: tb/tb_llsc_reservation_unit.sv
// Directed plus random bench for llsc_reservation_unit, driving a TIMEOUT=0 and a
// TIMEOUT=4 instance with identical stimulus against a granule-level reference model.
module tb_llsc_reservation_unit;

    logic        clk;
    logic        rst;
    logic [1:0]  ll_we, sc_req, st_we, flush;
    logic [63:0] ll_addr, sc_addr, st_addr;
    logic        ext_wr;
    logic [31:0] ext_addr;

    logic [1:0]  sc_ok0, sc_ok1, llbit0, llbit1;
    logic [63:0] lladdr0, lladdr1;

    int compared   = 0;
    int mismatched = 0;

    logic        m_valid [2][2];
    logic [31:0] m_addr  [2][2];
    int          m_age   [2][2];
    int          tmo     [2] = '{0, 4};
    logic [31:0] pool    [3] = '{32'h100, 32'h104, 32'h200};

    llsc_reservation_unit #(.N_CH(2), .ADDR_W(32), .GRAN_LOG2(2), .TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst), .ll_we(ll_we), .ll_addr(ll_addr), .sc_req(sc_req),
        .sc_addr(sc_addr), .sc_ok(sc_ok0), .st_we(st_we), .st_addr(st_addr),
        .ext_wr(ext_wr), .ext_addr(ext_addr), .flush(flush), .llbit(llbit0), .lladdr(lladdr0)
    );

    llsc_reservation_unit #(.N_CH(2), .ADDR_W(32), .GRAN_LOG2(2), .TIMEOUT(4)) dut1 (
        .clk(clk), .rst(rst), .ll_we(ll_we), .ll_addr(ll_addr), .sc_req(sc_req),
        .sc_addr(sc_addr), .sc_ok(sc_ok1), .st_we(st_we), .st_addr(st_addr),
        .ext_wr(ext_wr), .ext_addr(ext_addr), .flush(flush), .llbit(llbit1), .lladdr(lladdr1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] chAddr(input logic [63:0] v, input int c);
        return v[c*32 +: 32];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: every write this cycle is a (writer, granule) pair; a link dies if someone
    // else wrote its granule, and SCs are granted lowest channel first
    task automatic modelEval(input int k, output logic [1:0] ok);
        int          who [$];
        logic [31:0] gr  [$];
        ok = 2'b00;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_valid[k][c] = 1'b0;
                m_addr[k][c]  = '0;
                m_age[k][c]   = 0;
            end
            return;
        end
        if (ext_wr) begin
            who.push_back(-1);
            gr.push_back(ext_addr >> 2);
        end
        for (int c = 0; c < 2; c++) begin
            if (st_we[c]) begin
                who.push_back(c);
                gr.push_back(chAddr(st_addr, c) >> 2);
            end
        end
        for (int c = 0; c < 2; c++) begin
            if (sc_req[c] && !flush[c] && m_valid[k][c]
                && (chAddr(sc_addr, c) >> 2) == (m_addr[k][c] >> 2)) begin
                logic lost;
                lost = 1'b0;
                for (int i = 0; i < who.size(); i++)
                    if (who[i] != c && gr[i] == (m_addr[k][c] >> 2)) lost = 1'b1;
                if (!lost) begin
                    ok[c] = 1'b1;
                    who.push_back(c);
                    gr.push_back(chAddr(sc_addr, c) >> 2);
                end
            end
        end
        for (int c = 0; c < 2; c++) begin
            logic killed;
            killed = 1'b0;
            for (int i = 0; i < who.size(); i++)
                if (who[i] != c && gr[i] == (m_addr[k][c] >> 2)) killed = 1'b1;
            if (flush[c]) begin
                m_valid[k][c] = 1'b0;
            end else if (ll_we[c]) begin
                m_valid[k][c] = 1'b1;
                m_addr[k][c]  = chAddr(ll_addr, c) & ~32'h3;
                m_age[k][c]   = 0;
            end else if (sc_req[c] || killed) begin
                m_valid[k][c] = 1'b0;
            end else if (m_valid[k][c]) begin
                m_age[k][c]++;
                if (tmo[k] > 0 && m_age[k][c] >= tmo[k]) m_valid[k][c] = 1'b0;
            end
        end
    endtask

    // Inputs are driven just after a rising edge; comb output checked before the next one
    task automatic applyStimulus();
        logic [1:0] e0, e1;
        #2;
        modelEval(0, e0);
        modelEval(1, e1);
        checkOutput("sc_ok_t0", sc_ok0, e0);
        checkOutput("sc_ok_t4", sc_ok1, e1);
        @(posedge clk);
        #1;
        checkOutput("llbit_t0", llbit0, {m_valid[0][1], m_valid[0][0]});
        checkOutput("llbit_t4", llbit1, {m_valid[1][1], m_valid[1][0]});
        checkOutput("lladdr_t0", lladdr0, {m_addr[0][1], m_addr[0][0]});
        checkOutput("lladdr_t4", lladdr1, {m_addr[1][1], m_addr[1][0]});
        rst = 1'b0; ll_we = '0; sc_req = '0; st_we = '0; flush = '0; ext_wr = 1'b0;
        ll_addr = '0; sc_addr = '0; st_addr = '0; ext_addr = '0;
    endtask

    task automatic doLL(input int c, input logic [31:0] a);
        ll_we[c] = 1'b1;
        ll_addr[c*32 +: 32] = a;
    endtask

    task automatic doSC(input int c, input logic [31:0] a);
        sc_req[c] = 1'b1;
        sc_addr[c*32 +: 32] = a;
    endtask

    task automatic doST(input int c, input logic [31:0] a);
        st_we[c] = 1'b1;
        st_addr[c*32 +: 32] = a;
    endtask

    initial begin
        rst = 1'b1; ll_we = '0; sc_req = '0; st_we = '0; flush = '0; ext_wr = 1'b0;
        ll_addr = '0; sc_addr = '0; st_addr = '0; ext_addr = '0;
        @(posedge clk);
        #1;

        rst = 1'b1;
        #1 checkOutput("rst_sc_ok", sc_ok0, 64'h0);
        applyStimulus();
        checkOutput("rst_llbit", llbit0, 64'h0);
        checkOutput("rst_lladdr", lladdr0, 64'h0);

        doLL(0, 32'h0);
        applyStimulus();
        checkOutput("ll0_llbit", llbit0, 64'h1);
        doSC(0, 32'h0);
        #1 checkOutput("sc0_ok", sc_ok0, 64'h1);
        applyStimulus();
        checkOutput("sc0_llbit_clr", llbit0, 64'h0);
        doSC(0, 32'h0);
        #1 checkOutput("sc0_second", sc_ok0, 64'h0);
        applyStimulus();

        doLL(0, 32'h8);
        applyStimulus();
        doSC(0, 32'hA);
        #1 checkOutput("gran_same_word", sc_ok0, 64'h1);
        applyStimulus();
        doLL(0, 32'h8);
        applyStimulus();
        doSC(0, 32'hC);
        #1 checkOutput("gran_next_word", sc_ok0, 64'h0);
        applyStimulus();

        doLL(0, 32'h4);
        applyStimulus();
        doST(1, 32'h4);
        applyStimulus();
        doSC(0, 32'h4);
        #1 checkOutput("other_store_kills", sc_ok0, 64'h0);
        applyStimulus();
        doLL(0, 32'h4);
        applyStimulus();
        doST(0, 32'h4);
        applyStimulus();
        doSC(0, 32'h4);
        #1 checkOutput("own_store_keeps", sc_ok0, 64'h1);
        applyStimulus();

        doLL(0, 32'h10);
        doLL(1, 32'h10);
        applyStimulus();
        doSC(0, 32'h10);
        doSC(1, 32'h10);
        #1 checkOutput("sc_vs_sc", sc_ok0, 64'h1);
        applyStimulus();
        checkOutput("sc_vs_sc_llbit", llbit0, 64'h0);

        doLL(0, 32'h20);
        ext_wr = 1'b1; ext_addr = 32'h20;
        applyStimulus();
        checkOutput("ll_beats_ext", llbit0, 64'h1);
        ext_wr = 1'b1; ext_addr = 32'h20;
        applyStimulus();
        checkOutput("ext_kills", llbit0, 64'h0);
        doSC(0, 32'h20);
        #1 checkOutput("ext_sc_fail", sc_ok0, 64'h0);
        applyStimulus();

        doLL(0, 32'h40);
        applyStimulus();
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("tmo_still_live", llbit1, 64'h1);
        applyStimulus();
        checkOutput("tmo_expired", llbit1, 64'h0);
        checkOutput("no_tmo_live", llbit0, 64'h1);
        doSC(0, 32'h40);
        #1 checkOutput("tmo_sc_fail", sc_ok1, 64'h0);
        checkOutput("no_tmo_sc_ok", sc_ok0, 64'h1);
        applyStimulus();

        doLL(0, 32'h50);
        applyStimulus();
        flush[0] = 1'b1;
        applyStimulus();
        doSC(0, 32'h50);
        #1 checkOutput("flush_sc_fail", sc_ok0, 64'h0);
        applyStimulus();
        doLL(0, 32'h60);
        applyStimulus();
        rst = 1'b1;
        applyStimulus();
        checkOutput("rst_mid_lladdr", lladdr0, 64'h0);
        doSC(0, 32'h60);
        #1 checkOutput("rst_mid_sc_fail", sc_ok0, 64'h0);
        applyStimulus();

        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 2; c++) begin
                int op;
                logic [31:0] a;
                op = int'($urandom_range(0, 11));
                a  = pool[$urandom_range(0, 2)] | 32'($urandom_range(0, 3));
                if (op < 2) doLL(c, a);
                else if (op < 4) doSC(c, a);
                else if (op == 4) doST(c, a);
                if ($urandom_range(0, 15) == 0) flush[c] = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) begin
                ext_wr   = 1'b1;
                ext_addr = pool[$urandom_range(0, 2)];
            end
            if ($urandom_range(0, 63) == 0) rst = 1'b1;
            applyStimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
